irq_ctrl: RTL and testbench

IRQ_CTRL -- requirements
Module: irq_ctrl

---
 rtl/irq_ctrl_if.sv | 11 +
 rtl/irq_ctrl.sv | 70 +++++++
 tb/tb_irq_ctrl.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/irq_ctrl_if.sv
// irq_ctrl_if: interrupt source, enable, CPU handshake and status signals of irq_ctrl
interface irq_ctrl_if #(
   parameter int NUM_IRQ = 8,
   parameter int ID_W = 3
);
   logic [NUM_IRQ-1:0] irq_in, irq_en, pending;
   logic claim, complete, irq_req, busy;
   logic [ID_W-1:0] irq_id;
   modport master (output irq_in, irq_en, claim, complete, input irq_req, irq_id, busy, pending);
   modport slave (input irq_in, irq_en, claim, complete, output irq_req, irq_id, busy, pending);
endinterface

// File: rtl/irq_ctrl.sv
// irq_ctrl: fixed-priority interrupt controller with IDLE/REQ/SERVICE handshake; define IRQ_CTRL_SYNC_EN to add a two-flop input synchroniser
module irq_ctrl #(
   parameter int NUM_IRQ = 8,
   parameter int ID_W = 3,
   parameter logic [NUM_IRQ-1:0] EDGE_MASK = '1
) (
   input logic clk,
   input logic rst,
   irq_ctrl_if.slave bus
);
   localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, SERVICE = 2'd2;
   logic [1:0] state;
   logic [NUM_IRQ-1:0] src, irq_prev, clr, cand;
   logic [ID_W-1:0] winner;
`ifdef IRQ_CTRL_SYNC_EN
   logic [NUM_IRQ-1:0] sync1, sync2;
   // two-flop synchroniser ahead of the edge/level logic
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= bus.irq_in;
         sync2 <= sync1;
      end
   assign src = sync2;
`else
   assign src = bus.irq_in;
`endif
   assign cand = bus.pending & bus.irq_en;
   assign clr = (state == REQ && bus.claim) ? EDGE_MASK & (NUM_IRQ'(1) << bus.irq_id) : '0;
   // lowest-index enabled pending channel wins
   always_comb begin
      winner = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--)
         if (cand[i]) winner = ID_W'(i);
   end
   // edge bits set on a rise (a rise beats the claim clear), level bits follow the source
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         irq_prev <= '0;
         bus.pending <= '0;
      end else begin
         irq_prev <= src;
         bus.pending <= (EDGE_MASK & ((bus.pending & ~clr) | (src & ~irq_prev))) | (~EDGE_MASK & src);
      end
   // request/claim/complete handshake; irq_id is frozen outside IDLE
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state <= IDLE;
         bus.irq_req <= 1'b0;
         bus.irq_id <= '0;
         bus.busy <= 1'b0;
      end else if (state == IDLE) begin
         if (|cand) begin
            state <= REQ;
            bus.irq_req <= 1'b1;
            bus.irq_id <= winner;
         end
      end else if (state == REQ) begin
         if (bus.claim) begin
            state <= SERVICE;
            bus.irq_req <= 1'b0;
            bus.busy <= 1'b1;
         end
      end else if (bus.complete) begin
         state <= IDLE;
         bus.busy <= 1'b0;
      end
endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed checks of irq_ctrl (edge instance plus an all-level instance)
module tb_irq_ctrl;
`ifdef IRQ_CTRL_SYNC_EN
   localparam int SL = 2;
`else
   localparam int SL = 0;
`endif
   logic clk, rst;
   int n_tests = 0, n_fail = 0;
   irq_ctrl_if #(.NUM_IRQ(8), .ID_W(3)) b ();
   irq_ctrl_if #(.NUM_IRQ(8), .ID_W(3)) b2 ();
   irq_ctrl #(.NUM_IRQ(8), .ID_W(3), .EDGE_MASK(8'hFF)) dut (.clk(clk), .rst(rst), .bus(b));
   irq_ctrl #(.NUM_IRQ(8), .ID_W(3), .EDGE_MASK(8'h00)) dut_lvl (.clk(clk), .rst(rst), .bus(b2));
   initial clk = 1'b0;
   always #5 clk = ~clk;
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask
   task automatic claim_complete;
      b.claim = 1'b1;
      tick();
      b.claim = 1'b0;
      b.complete = 1'b1;
      tick();
      b.complete = 1'b0;
   endtask
   task automatic test_reset;
      n_tests++; if ({b.irq_req, b.busy, b.irq_id, b.pending} !== 12'h0) begin n_fail++; $display("FAIL reset_state got req=%b busy=%b id=%0d pend=%h want all 0", b.irq_req, b.busy, b.irq_id, b.pending); end
      tick();
      n_tests++; if ({b.irq_req, b.busy, b.pending} !== 10'h0) begin n_fail++; $display("FAIL reset_idle got req=%b busy=%b pend=%h want 0", b.irq_req, b.busy, b.pending); end
   endtask
   task automatic test_single_edge;
      b.irq_in = 8'h08;
      tick();
      b.irq_in = 8'h00;
      ticks(SL);
      n_tests++; if (b.pending !== 8'h08 || b.irq_req !== 1'b0) begin n_fail++; $display("FAIL edge_pending got pend=%h req=%b want pend=08 req=0", b.pending, b.irq_req); end
      tick();
      n_tests++; if (b.irq_req !== 1'b1 || b.irq_id !== 3'd3) begin n_fail++; $display("FAIL edge_req got req=%b id=%0d want req=1 id=3", b.irq_req, b.irq_id); end
      b.claim = 1'b1;
      tick();
      b.claim = 1'b0;
      n_tests++; if (b.busy !== 1'b1 || b.irq_req !== 1'b0 || b.pending !== 8'h00) begin n_fail++; $display("FAIL edge_claim got busy=%b req=%b pend=%h want busy=1 req=0 pend=00", b.busy, b.irq_req, b.pending); end
      b.complete = 1'b1;
      tick();
      b.complete = 1'b0;
      n_tests++; if (b.busy !== 1'b0 || b.irq_req !== 1'b0 || b.irq_id !== 3'd3) begin n_fail++; $display("FAIL edge_complete got busy=%b req=%b id=%0d want busy=0 req=0 id=3", b.busy, b.irq_req, b.irq_id); end
      tick();
      n_tests++; if (b.irq_req !== 1'b0) begin n_fail++; $display("FAIL edge_idle got req=%b want 0", b.irq_req); end
   endtask
   task automatic test_priority;
      b.irq_in = 8'h44;
      tick();
      b.irq_in = 8'h00;
      ticks(SL);
      n_tests++; if (b.pending !== 8'h44) begin n_fail++; $display("FAIL prio_pending got %h want 44", b.pending); end
      tick();
      n_tests++; if (b.irq_req !== 1'b1 || b.irq_id !== 3'd2) begin n_fail++; $display("FAIL prio_first got req=%b id=%0d want req=1 id=2", b.irq_req, b.irq_id); end
      claim_complete();
      tick();
      n_tests++; if (b.irq_req !== 1'b1 || b.irq_id !== 3'd6) begin n_fail++; $display("FAIL prio_second got req=%b id=%0d want req=1 id=6", b.irq_req, b.irq_id); end
      b.irq_in = 8'h01;
      tick();
      b.irq_in = 8'h00;
      ticks(SL);
      n_tests++; if (b.pending !== 8'h41 || b.irq_id !== 3'd6) begin n_fail++; $display("FAIL prio_frozen got pend=%h id=%0d want pend=41 id=6", b.pending, b.irq_id); end
      claim_complete();
      tick();
      n_tests++; if (b.irq_req !== 1'b1 || b.irq_id !== 3'd0) begin n_fail++; $display("FAIL prio_third got req=%b id=%0d want req=1 id=0", b.irq_req, b.irq_id); end
      claim_complete();
   endtask
   task automatic test_enable_mask;
      b.irq_en = 8'hFB;
      b.irq_in = 8'h04;
      tick();
      b.irq_in = 8'h00;
      ticks(SL + 2);
      n_tests++; if (b.pending !== 8'h04 || b.irq_req !== 1'b0) begin n_fail++; $display("FAIL mask_hold got pend=%h req=%b want pend=04 req=0", b.pending, b.irq_req); end
      b.irq_en = 8'hFF;
      tick();
      n_tests++; if (b.irq_req !== 1'b1 || b.irq_id !== 3'd2) begin n_fail++; $display("FAIL mask_release got req=%b id=%0d want req=1 id=2", b.irq_req, b.irq_id); end
      claim_complete();
   endtask
   task automatic test_ignored_handshake;
      b.claim = 1'b1;
      b.complete = 1'b1;
      tick();
      b.claim = 1'b0;
      b.complete = 1'b0;
      n_tests++; if (b.busy !== 1'b0 || b.irq_req !== 1'b0) begin n_fail++; $display("FAIL idle_claim got busy=%b req=%b want 0 0", b.busy, b.irq_req); end
      b.irq_in = 8'h02;
      tick();
      b.irq_in = 8'h00;
      ticks(SL + 1);
      b.complete = 1'b1;
      tick();
      b.complete = 1'b0;
      n_tests++; if (b.irq_req !== 1'b1 || b.busy !== 1'b0 || b.irq_id !== 3'd1) begin n_fail++; $display("FAIL req_complete got req=%b busy=%b id=%0d want req=1 busy=0 id=1", b.irq_req, b.busy, b.irq_id); end
      claim_complete();
   endtask
   task automatic test_set_wins;
      b.irq_in = 8'h20;
      tick();
      b.irq_in = 8'h00;
      ticks(SL + 2);
      n_tests++; if (b.irq_req !== 1'b1 || b.irq_id !== 3'd5) begin n_fail++; $display("FAIL setwin_req got req=%b id=%0d want req=1 id=5", b.irq_req, b.irq_id); end
      b.irq_in = 8'h20;
      b.claim = 1'b1;
      tick();
      b.claim = 1'b0;
      b.irq_in = 8'h00;
      ticks(SL);
      n_tests++; if (b.pending !== 8'h20 || b.busy !== 1'b1) begin n_fail++; $display("FAIL setwin_pending got pend=%h busy=%b want pend=20 busy=1", b.pending, b.busy); end
      b.complete = 1'b1;
      tick();
      b.complete = 1'b0;
      tick();
      n_tests++; if (b.irq_req !== 1'b1 || b.irq_id !== 3'd5) begin n_fail++; $display("FAIL setwin_rereq got req=%b id=%0d want req=1 id=5", b.irq_req, b.irq_id); end
      claim_complete();
   endtask
   task automatic test_level;
      b2.irq_en = 8'hFF;
      b2.irq_in = 8'h02;
      tick();
      ticks(SL);
      n_tests++; if (b2.pending !== 8'h02) begin n_fail++; $display("FAIL lvl_pending got %h want 02", b2.pending); end
      tick();
      n_tests++; if (b2.irq_req !== 1'b1 || b2.irq_id !== 3'd1) begin n_fail++; $display("FAIL lvl_req got req=%b id=%0d want req=1 id=1", b2.irq_req, b2.irq_id); end
      b2.claim = 1'b1;
      tick();
      b2.claim = 1'b0;
      n_tests++; if (b2.busy !== 1'b1 || b2.pending !== 8'h02) begin n_fail++; $display("FAIL lvl_claim got busy=%b pend=%h want busy=1 pend=02", b2.busy, b2.pending); end
      b2.complete = 1'b1;
      tick();
      b2.complete = 1'b0;
      n_tests++; if (b2.busy !== 1'b0 || b2.irq_req !== 1'b0) begin n_fail++; $display("FAIL lvl_complete got busy=%b req=%b want 0 0", b2.busy, b2.irq_req); end
      tick();
      n_tests++; if (b2.irq_req !== 1'b1 || b2.irq_id !== 3'd1) begin n_fail++; $display("FAIL lvl_rereq got req=%b id=%0d want req=1 id=1", b2.irq_req, b2.irq_id); end
      b2.irq_in = 8'h00;
      ticks(SL + 1);
      n_tests++; if (b2.pending !== 8'h00) begin n_fail++; $display("FAIL lvl_drop got %h want 00", b2.pending); end
      b2.claim = 1'b1;
      tick();
      b2.claim = 1'b0;
      b2.complete = 1'b1;
      tick();
      b2.complete = 1'b0;
   endtask
   task automatic test_async_reset;
      b.irq_in = 8'h10;
      tick();
      b.irq_in = 8'h00;
      ticks(SL + 1);
      b.claim = 1'b1;
      tick();
      b.claim = 1'b0;
      b.irq_in = 8'h01;
      #1;
      n_tests++; if (b.busy !== 1'b1 || b.irq_id !== 3'd4) begin n_fail++; $display("FAIL arst_setup got busy=%b id=%0d want busy=1 id=4", b.busy, b.irq_id); end
      #1 rst = 1'b0;
      #1;
      n_tests++; if ({b.irq_req, b.busy, b.irq_id, b.pending} !== 12'h0) begin n_fail++; $display("FAIL arst_clear got req=%b busy=%b id=%0d pend=%h want all 0", b.irq_req, b.busy, b.irq_id, b.pending); end
      b.irq_in = 8'h80;
      tick();
      n_tests++; if (b.pending !== 8'h00) begin n_fail++; $display("FAIL arst_hold got pend=%h want 00", b.pending); end
      #2 rst = 1'b1;
      tick();
      ticks(SL);
      n_tests++; if (b.pending !== 8'h80) begin n_fail++; $display("FAIL arst_release got pend=%h want 80", b.pending); end
      tick();
      n_tests++; if (b.irq_req !== 1'b1 || b.irq_id !== 3'd7) begin n_fail++; $display("FAIL arst_req got req=%b id=%0d want req=1 id=7", b.irq_req, b.irq_id); end
      claim_complete();
      b.irq_in = 8'h00;
   endtask
   initial begin
      rst = 1'b0;
      b.irq_in = '0; b.irq_en = 8'hFF; b.claim = 1'b0; b.complete = 1'b0;
      b2.irq_in = '0; b2.irq_en = '0; b2.claim = 1'b0; b2.complete = 1'b0;
      #12 rst = 1'b1;
      test_reset();
      test_single_edge();
      test_priority();
      test_enable_mask();
      test_ignored_handshake();
      test_set_wins();
      test_level();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
